// File: rtl/i_buffer.sv
// Per-warp instruction buffer: NW circular FIFOs filled by two decode lanes,
// drained one entry per cycle by a one-hot issue grant with one cycle of latency.
module i_buffer #(
   parameter int DEPTH = 4,
   parameter int NW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NW-1:0] Valid_ID0_IB,
   input  logic [31:0]   Instr_ID0_IB,
   input  logic [31:0]   PC_plus4_ID0_IB,
   input  logic [NW-1:0] Valid_ID1_IB,
   input  logic [31:0]   Instr_ID1_IB,
   input  logic [31:0]   PC_plus4_ID1_IB,
   input  logic [NW-1:0] Flush_IB,
   input  logic [NW-1:0] Grant_IS_IB,
   output logic [31:0]   Instr_IB_IS,
   output logic [31:0]   PC_plus4_IB_IS,
   output logic          Valid_IB_IS,
   output logic [2:0]    WarpID_IB_IS,
   output logic [NW-1:0] Full_IB_IF,
   output logic [NW-1:0] AFull_IB_IF,
   output logic [NW-1:0] Empty_IB_IS,
   output logic [NW-1:0] Ovf_IB
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   mem [NW][DEPTH];
   logic [AW-1:0] head_q [NW], head_d [NW];
   logic [AW-1:0] tail_q [NW], tail_d [NW];
   logic [AW-1:0] waddr0 [NW], waddr1 [NW];
   logic [CW-1:0] count_q [NW], count_d [NW];
   logic [NW-1:0] ovf_q, ovf_d;
   logic [NW-1:0] wr0, wr1, acc0, acc1, rd;
   logic          lane0_ok, lane1_ok, grant_ok;
   logic          rd_any;
   logic [2:0]    rd_idx;
   logic [63:0]   rd_data;

   function automatic logic is_onehot(input logic [NW-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      lane0_ok = is_onehot(Valid_ID0_IB);
      lane1_ok = is_onehot(Valid_ID1_IB);
      grant_ok = is_onehot(Grant_IS_IB);
      rd_any   = 1'b0;
      rd_idx   = '0;
      rd_data  = '0;
      ovf_d    = ovf_q;
      for (int i = 0; i < NW; i++) begin
         wr0[i]     = lane0_ok && Valid_ID0_IB[i];
         wr1[i]     = lane1_ok && Valid_ID1_IB[i];
         acc0[i]    = 1'b0;
         acc1[i]    = 1'b0;
         rd[i]      = 1'b0;
         head_d[i]  = head_q[i];
         tail_d[i]  = tail_q[i];
         count_d[i] = count_q[i];
         waddr0[i]  = tail_q[i];
         waddr1[i]  = tail_q[i];
         if (Flush_IB[i]) begin
            head_d[i]  = '0;
            tail_d[i]  = '0;
            count_d[i] = '0;
         end else begin
            // Space is judged on the start-of-cycle count; a same-cycle read frees nothing.
            acc0[i]   = wr0[i] && (count_q[i] < CW'(DEPTH));
            acc1[i]   = wr1[i] && ((count_q[i] + CW'(acc0[i])) < CW'(DEPTH));
            waddr1[i] = tail_q[i] + AW'(acc0[i]);
            rd[i]     = grant_ok && Grant_IS_IB[i] && (count_q[i] != '0);
            if ((wr0[i] && !acc0[i]) || (wr1[i] && !acc1[i]))
               ovf_d[i] = 1'b1;
            if (rd[i]) begin
               rd_any    = 1'b1;
               rd_idx    = 3'(i);
               rd_data   = mem[i][head_q[i]];
               head_d[i] = head_q[i] + 1'b1;
            end
            tail_d[i]  = tail_q[i] + AW'(acc0[i]) + AW'(acc1[i]);
            count_d[i] = count_q[i] + CW'(acc0[i]) + CW'(acc1[i]) - CW'(rd[i]);
         end
      end
   end

   // NOTE: storage has no reset; the pointers and counts alone define which entries are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NW; i++) begin
         if (acc0[i]) mem[i][waddr0[i]] <= {Instr_ID0_IB, PC_plus4_ID0_IB};
         if (acc1[i]) mem[i][waddr1[i]] <= {Instr_ID1_IB, PC_plus4_ID1_IB};
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) begin
            head_q[i]  <= '0;
            tail_q[i]  <= '0;
            count_q[i] <= '0;
         end
         ovf_q          <= '0;
         Valid_IB_IS    <= 1'b0;
         Instr_IB_IS    <= '0;
         PC_plus4_IB_IS <= '0;
         WarpID_IB_IS   <= '0;
      end else begin
         for (int i = 0; i < NW; i++) begin
            head_q[i]  <= head_d[i];
            tail_q[i]  <= tail_d[i];
            count_q[i] <= count_d[i];
         end
         ovf_q       <= ovf_d;
         Valid_IB_IS <= rd_any;
         if (rd_any) begin
            Instr_IB_IS    <= rd_data[63:32];
            PC_plus4_IB_IS <= rd_data[31:0];
            WarpID_IB_IS   <= rd_idx;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NW; i++) begin
         Full_IB_IF[i]  = (count_q[i] == CW'(DEPTH));
         AFull_IB_IF[i] = (count_q[i] >= CW'(DEPTH - 2));
         Empty_IB_IS[i] = (count_q[i] == '0);
      end
   end

   assign Ovf_IB = ovf_q;
endmodule

// File: tb/tb_i_buffer.sv
// Self-checking bench for i_buffer: directed scenarios plus random traffic,
// all scored against a queue-per-warp reference model.
module tb_i_buffer;
   localparam int DEPTH = 4;
   localparam int NW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NW-1:0] v0, v1, fl, gr;
   logic [31:0]   i0, p0, i1, p1;
   logic [31:0]   instr_o, pc_o;
   logic          valid_o;
   logic [2:0]    wid_o;
   logic [NW-1:0] full_o, afull_o, empty_o, ovf_o;

   i_buffer #(.DEPTH(DEPTH), .NW(NW)) dut (
      .clk(clk), .rst_n(rst_n),
      .Valid_ID0_IB(v0), .Instr_ID0_IB(i0), .PC_plus4_ID0_IB(p0),
      .Valid_ID1_IB(v1), .Instr_ID1_IB(i1), .PC_plus4_ID1_IB(p1),
      .Flush_IB(fl), .Grant_IS_IB(gr),
      .Instr_IB_IS(instr_o), .PC_plus4_IB_IS(pc_o), .Valid_IB_IS(valid_o),
      .WarpID_IB_IS(wid_o), .Full_IB_IF(full_o), .AFull_IB_IF(afull_o),
      .Empty_IB_IS(empty_o), .Ovf_IB(ovf_o)
   );

   always #5 clk = ~clk;

   // Reference model: one queue of {instr, pc} per warp.
   logic [63:0]   mq [NW][$];
   logic [NW-1:0] m_ovf;
   logic          e_valid;
   logic [31:0]   e_instr, e_pc;
   logic [2:0]    e_wid;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NW-1:0] v);
      for (int k = 0; k < NW; k++) if (v[k]) return k;
      return 0;
   endfunction

   task automatic model_update();
      int g;
      int sz [NW];
      if (!rst_n) begin
         for (int w = 0; w < NW; w++) mq[w].delete();
         m_ovf = '0; e_valid = 1'b0; e_instr = '0; e_pc = '0; e_wid = '0;
         return;
      end
      for (int w = 0; w < NW; w++) sz[w] = mq[w].size();
      for (int w = 0; w < NW; w++) begin
         if (fl[w]) begin
            mq[w].delete();
         end else begin
            if ($onehot(v0) && v0[w]) begin
               if (mq[w].size() < DEPTH) mq[w].push_back({i0, p0});
               else m_ovf[w] = 1'b1;
            end
            if ($onehot(v1) && v1[w]) begin
               if (mq[w].size() < DEPTH) mq[w].push_back({i1, p1});
               else m_ovf[w] = 1'b1;
            end
         end
      end
      e_valid = 1'b0;
      if ($onehot(gr)) begin
         g = onehot_idx(gr);
         if (!fl[g] && sz[g] > 0) begin
            {e_instr, e_pc} = mq[g].pop_front();
            e_valid = 1'b1;
            e_wid   = 3'(g);
         end
      end
   endtask

   task automatic compare_all();
      logic [NW-1:0] ef, ea, ee;
      for (int w = 0; w < NW; w++) begin
         ef[w] = (mq[w].size() == DEPTH);
         ea[w] = (mq[w].size() >= DEPTH - 2);
         ee[w] = (mq[w].size() == 0);
      end
      check("valid", 64'(valid_o), 64'(e_valid));
      check("instr", 64'(instr_o), 64'(e_instr));
      check("pc",    64'(pc_o),    64'(e_pc));
      if (e_valid) check("warpid", 64'(wid_o), 64'(e_wid));
      check("full",  64'(full_o),  64'(ef));
      check("afull", 64'(afull_o), 64'(ea));
      check("empty", 64'(empty_o), 64'(ee));
      check("ovf",   64'(ovf_o),   64'(m_ovf));
   endtask

   task automatic step(input logic [NW-1:0] a0, input logic [31:0] d0,
                       input logic [NW-1:0] a1, input logic [31:0] d1,
                       input logic [NW-1:0] f, input logic [NW-1:0] g);
      @(negedge clk);
      v0 = a0; i0 = d0; p0 = d0 + 32'h1000;
      v1 = a1; i1 = d1; p1 = d1 + 32'h2000;
      fl = f;  gr = g;
      model_update();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step('0, '0, '0, '0, '0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(8'hFF, 32'hDEAD, 8'h01, 32'hBEEF, 8'h02, 8'h04);
      rst_n = 1'b1;
   endtask

   function automatic logic [NW-1:0] rand_sel();
      int r = $urandom_range(0, 9);
      if (r < 6) return NW'(1) << $urandom_range(0, NW - 1);
      if (r < 8) return '0;
      return NW'($urandom);
   endfunction

   initial begin
      rst_n = 1'b0;
      v0 = '0; v1 = '0; fl = '0; gr = '0; i0 = '0; p0 = '0; i1 = '0; p1 = '0;
      do_reset();
      check("rst_empty", 64'(empty_o), 64'(8'hFF));
      check("rst_full",  64'(full_o),  64'(0));

      // Fill and drain warp 3.
      for (int k = 0; k < 4; k++) step(8'h08, 32'hA0 + k, '0, '0, '0, '0);
      check("fill_full3", 64'(full_o[3]), 64'(1));
      for (int k = 0; k < 4; k++) begin
         step('0, '0, '0, '0, '0, 8'h08);
         check("drain_data", 64'(instr_o), 64'(32'hA0 + k));
         check("drain_wid",  64'(wid_o),   64'(3));
      end
      check("drain_empty3", 64'(empty_o[3]), 64'(1));

      // Dual lane into warp 5 with a single free slot.
      for (int k = 0; k < 3; k++) step(8'h20, 32'h50 + k, '0, '0, '0, '0);
      step(8'h20, 32'h11, 8'h20, 32'h22, '0, '0);
      check("dual_ovf5",  64'(ovf_o[5]),  64'(1));
      check("dual_full5", 64'(full_o[5]), 64'(1));
      for (int k = 0; k < 4; k++) step('0, '0, '0, '0, '0, 8'h20);
      check("dual_last", 64'(instr_o), 64'(32'h11));

      // Wrap-around on warp 0.
      for (int k = 0; k < 10; k++) begin
         step(8'h01, k, '0, '0, '0, '0);
         step('0, '0, '0, '0, '0, 8'h01);
         check("wrap_data", 64'(instr_o), 64'(k));
      end

      // Flush beats same-cycle write and grant on warp 2.
      step(8'h04, 32'h70, 8'h04, 32'h71, '0, '0);
      step(8'h04, 32'h72, '0, '0, 8'h04, 8'h04);
      check("flush_valid", 64'(valid_o),     64'(0));
      check("flush_empty", 64'(empty_o[2]),  64'(1));
      check("flush_ovf",   64'(ovf_o[2]),    64'(0));

      // Read of empty warp 7 alongside a write.
      step(8'h80, 32'h55, '0, '0, '0, 8'h80);
      check("emptyrd_valid", 64'(valid_o),    64'(0));
      check("emptyrd_cnt",   64'(empty_o[7]), 64'(0));
      step('0, '0, '0, '0, '0, 8'h80);
      check("emptyrd_data", 64'(instr_o), 64'(32'h55));

      // Reset mid-operation.
      step(8'h02, 32'h90, 8'h40, 32'h91, '0, '0);
      step(8'h10, 32'h92, 8'h10, 32'h93, '0, 8'h02);
      do_reset();
      check("mrst_valid", 64'(valid_o), 64'(0));
      check("mrst_instr", 64'(instr_o), 64'(0));
      check("mrst_empty", 64'(empty_o), 64'(8'hFF));
      check("mrst_afull", 64'(afull_o), 64'(0));
      check("mrst_ovf",   64'(ovf_o),   64'(0));

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(rand_sel(), $urandom, rand_sel(), $urandom,
                 ($urandom_range(0, 19) == 0) ? rand_sel() : '0, rand_sel());
         end
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
